// File: rtl/run_length_decode.sv
// Run-length decoder: expands the encoder's token stream (nonzero literal,
// or 0x0000 marker followed by a count N) back into exactly pixelCount words
// per frame. frame_done marks the last word of each frame; malformed runs set
// the sticky proto_err flag.
// Optional build macro: RLD_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module run_length_decode #(
    parameter int unsigned pixelCount = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] input_S1,
    input  logic        avail_S1,
    output logic        read_S1,
    output logic [15:0] output_S2,
    output logic        write_S2,
    input  logic        full_S2,
    output logic        running,
    output logic        frame_done,
    output logic        proto_err
`ifdef RLD_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [15:0] PixTotal = 16'(pixelCount);
    localparam logic [15:0] PixLast  = 16'(pixelCount - 1);

    typedef enum logic [1:0] {StFetch, StGetCnt, StEmitL, StEmitZ} state_e;

    state_e      state;
    logic [15:0] pix_cnt;
    logic [15:0] run_cnt;
    logic [15:0] lit;

    logic        fetching;
    logic        emitting;
    logic        last_pix;
    logic [15:0] remaining;
    logic [15:0] next_pix;

    // Strobes and status derived from the current state and handshake inputs.
    always_comb begin
        fetching   = (state == StFetch) || (state == StGetCnt);
        emitting   = (state == StEmitL) || (state == StEmitZ);
        last_pix   = (pix_cnt == PixLast);
        // Always >= 1 because pix_cnt never reaches pixelCount.
        remaining  = PixTotal - pix_cnt;
        next_pix   = last_pix ? 16'd0 : pix_cnt + 16'd1;
        read_S1    = fetching && avail_S1;
        write_S2   = emitting && !full_S2;
        output_S2  = (state == StEmitL) ? lit : 16'd0;
        frame_done = write_S2 && last_pix;
        running    = !(fetching && !avail_S1);
    end

    // Decoder FSM with pixel and run counters; full_S2 stalls all emit-state updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StFetch;
            pix_cnt   <= 16'd0;
            run_cnt   <= 16'd0;
            lit       <= 16'd0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                StFetch: begin
                    if (avail_S1) begin
                        if (input_S1 != 16'd0) begin
                            lit   <= input_S1;
                            state <= StEmitL;
                        end else begin
                            state <= StGetCnt;
                        end
                    end
                end
                StGetCnt: begin
                    if (avail_S1) begin
                        if (input_S1 == 16'd0) begin
                            proto_err <= 1'b1;
                            state     <= StFetch;
                        end else if (input_S1 > remaining) begin
                            // Clip so the run ends on the frame boundary; excess is dropped.
                            run_cnt   <= remaining;
                            proto_err <= 1'b1;
                            state     <= StEmitZ;
                        end else begin
                            run_cnt <= input_S1;
                            state   <= StEmitZ;
                        end
                    end
                end
                StEmitL: begin
                    if (write_S2) begin
                        pix_cnt <= next_pix;
                        state   <= StFetch;
                    end
                end
                StEmitZ: begin
                    if (write_S2) begin
                        run_cnt <= run_cnt - 16'd1;
                        pix_cnt <= next_pix;
                        if (run_cnt == 16'd1) begin
                            state <= StFetch;
                        end
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

`ifdef RLD_ERR_COUNT_EN
    logic err_event;

    // Same conditions that set proto_err: zero count or clipped run.
    always_comb begin
        err_event = (state == StGetCnt) && avail_S1 &&
                    ((input_S1 == 16'd0) || (input_S1 > remaining));
    end

    // Saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_run_length_decode.sv
// Directed bench for run_length_decode with an 8-pixel frame.
module tb_run_length_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] input_S1 = 16'd0;
    logic        avail_S1 = 1'b0;
    logic        read_S1;
    logic [15:0] output_S2;
    logic        write_S2;
    logic        full_S2 = 1'b0;
    logic        running;
    logic        frame_done;
    logic        proto_err;
`ifdef RLD_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] tokq[$];
    logic [15:0] outs[$];
    bit          rd_hist[$];
    bit          wr_hist[$];
    int          fd_cnt;
    int          fd_idx;
    int          run_low;

    run_length_decode #(.pixelCount(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .input_S1   (input_S1),
        .avail_S1   (avail_S1),
        .read_S1    (read_S1),
        .output_S2  (output_S2),
        .write_S2   (write_S2),
        .full_S2    (full_S2),
        .running    (running),
        .frame_done (frame_done),
        .proto_err  (proto_err)
`ifdef RLD_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_in();
        avail_S1 = (tokq.size() != 0);
        input_S1 = avail_S1 ? tokq[0] : 16'd0;
    endtask

    task automatic clear_log();
        outs.delete();
        rd_hist.delete();
        wr_hist.delete();
        fd_cnt  = 0;
        fd_idx  = 0;
        run_low = 0;
    endtask

    // One clock: sample at the falling edge, pop the token model after the rising edge.
    task automatic cyc();
        bit rd;
        @(negedge clk);
        rd = read_S1;
        if (write_S2) begin
            outs.push_back(output_S2);
            if (frame_done) begin
                fd_cnt++;
                fd_idx = outs.size();
            end
        end else if (frame_done) begin
            fd_cnt += 100;
        end
        if (!running) run_low++;
        rd_hist.push_back(rd);
        wr_hist.push_back(write_S2);
        @(posedge clk);
        #1;
        if (rd && tokq.size() != 0) void'(tokq.pop_front());
        update_in();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tokq.delete();
        full_S2 = 1'b0;
        update_in();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    function automatic logic [31:0] pack(input bit h[$]);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < h.size(); i++) v = {v[30:0], h[i]};
        return v;
    endfunction

    initial begin
        // Reset state
        do_reset();
        chk("rst_read", read_S1, 0);
        chk("rst_write", write_S2, 0);
        chk("rst_out", output_S2, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_running", running, 0);

        // 1: literals 5,9,3
        do_reset();
        tokq = '{16'd5, 16'd9, 16'd3};
        update_in();
        cycles(6);
        chk("t1_n", outs.size(), 3);
        chk("t1_o0", outs[0], 5);
        chk("t1_o1", outs[1], 9);
        chk("t1_o2", outs[2], 3);
        chk("t1_rd", pack(rd_hist), 32'b101010);
        chk("t1_wr", pack(wr_hist), 32'b010101);
        chk("t1_running", run_low, 0);

        // 2: 7, run of 4 zeros, 2
        do_reset();
        tokq = '{16'd7, 16'd0, 16'd4, 16'd2};
        update_in();
        cycles(10);
        chk("t2_n", outs.size(), 6);
        chk("t2_o0", outs[0], 7);
        chk("t2_o1", outs[1] | outs[2] | outs[3] | outs[4], 0);
        chk("t2_o5", outs[5], 2);
        chk("t2_wr", pack(wr_hist), 32'b0100111101);
        chk("t2_err", proto_err, 0);
        chk("t2_fd", fd_cnt, 0);

        // 3: full-frame run of 8, twice
        do_reset();
        tokq = '{16'd0, 16'd8};
        update_in();
        cycles(10);
        chk("t3_n", outs.size(), 8);
        chk("t3_fd_cnt", fd_cnt, 1);
        chk("t3_fd_idx", fd_idx, 8);
        tokq = '{16'd0, 16'd8};
        update_in();
        cycles(10);
        chk("t3_fd_cnt2", fd_cnt, 2);
        chk("t3_fd_idx2", fd_idx, 16);
        chk("t3_err", proto_err, 0);

        // 4: clipped run then literal starts new frame
        do_reset();
        tokq = '{16'd1, 16'd0, 16'd20, 16'd6};
        update_in();
        cycles(13);
        chk("t4_n", outs.size(), 9);
        chk("t4_o0", outs[0], 1);
        chk("t4_o7", outs[7], 0);
        chk("t4_o8", outs[8], 6);
        chk("t4_fd_cnt", fd_cnt, 1);
        chk("t4_fd_idx", fd_idx, 8);
        chk("t4_err", proto_err, 1);
`ifdef RLD_ERR_COUNT_EN
        chk("t4_errcnt", err_count, 1);
`endif

        // 5: zero count is an error and emits nothing
        do_reset();
        tokq = '{16'd0, 16'd0, 16'd3};
        update_in();
        cycles(5);
        chk("t5_n", outs.size(), 1);
        chk("t5_o0", outs[0], 3);
        chk("t5_err", proto_err, 1);
`ifdef RLD_ERR_COUNT_EN
        chk("t5_errcnt", err_count, 1);
`endif

        // 6: backpressure mid-run of 4, then on a literal
        do_reset();
        tokq = '{16'd0, 16'd4};
        update_in();
        cycles(3);
        chk("t6_first", outs.size(), 1);
        full_S2 = 1'b1;
        cycles(5);
        chk("t6_hold_n", outs.size(), 1);
        chk("t6_hold_out", output_S2, 0);
        full_S2 = 1'b0;
        wr_hist.delete();
        cycles(4);
        chk("t6_n", outs.size(), 4);
        chk("t6_wr", pack(wr_hist), 32'b1110);
        tokq = '{16'hABCD};
        update_in();
        full_S2 = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_lit_out", output_S2, 16'hABCD);
            chk("t6_lit_wr", write_S2, 0);
        end
        full_S2 = 1'b0;
        cyc();
        chk("t6_lit_n", outs.size(), 5);
        chk("t6_lit_val", outs[4], 16'hABCD);

        // 7: asynchronous reset mid-run
        do_reset();
        tokq = '{16'd0, 16'd5};
        update_in();
        cycles(4);
        chk("t7_pre_wr", write_S2, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_wr", write_S2, 0);
        chk("t7_out", output_S2, 0);
        chk("t7_rd", read_S1, 0);
        chk("t7_running", running, 0);
        chk("t7_fd", frame_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        tokq = '{16'h0042};
        update_in();
        cycles(3);
        chk("t7_n", outs.size(), 1);
        chk("t7_o0", outs[0], 16'h0042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
